// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the shared-data-bus arbiter.
// The state enum doubles as the IDLE/OWN encoding constants.
package bus_arb_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    localparam int BUS_W = 32;
    localparam int BUS_N = 4;

    // Lock counter has to represent 0..max_lock inclusive.
    function automatic int cnt_width(input int max_lock);
        return $clog2(max_lock + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first asserted request at or above ptr wins,
// wrapping modulo N.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          any
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        any   = |req;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with bounded lock and destination load-enable fan-out.
// It drives the shared bus and register enables from the current owner's slice.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N        = BUS_N,
    parameter int W        = BUS_W,
    parameter int M        = 8,
    parameter int MAX_LOCK = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    input  logic [N*W-1:0] data_in,
    input  logic [N*M-1:0] ld_mask,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   bus,
    output logic [M-1:0]   ld_en,
    output logic           busy,
    output logic           timeout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = cnt_width(MAX_LOCK);

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    logic [N-1:0]  pick;
    logic          any;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] ptr_nxt;
    logic [N-1:0]  xfer;
    logic          own_lock;
    logic          rearb;

    rr_picker #(
        .N  (N),
        .PW (PW)
    ) u_picker (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
        ptr_nxt = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + PW'(1);
    end

    // gnt_q is one-hot, so reducing over all requesters isolates the owner.
    assign xfer     = gnt_q & req;
    assign own_lock = |(gnt_q & req & lock);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        rearb     = 1'b0;

        case (state_q)
            S_IDLE: begin
                rearb = any;
            end
            S_OWN: begin
                if (own_lock && (cnt_q < CW'(MAX_LOCK))) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    timeout_d = own_lock;
                    rearb     = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        // Rearbitration keeps ptr past the old owner, so it gets lowest priority.
        if (rearb) begin
            if (any) begin
                gnt_d   = pick;
                ptr_d   = ptr_nxt;
                cnt_d   = CW'(1);
                state_d = S_OWN;
            end else begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        bus   = '0;
        ld_en = '0;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                bus   = bus | data_in[i*W +: W];
                ld_en = ld_en | ld_mask[i*M +: M];
            end
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q == S_OWN);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: fixed vector table, reset corner sequences, and random
// traffic checked against a behavioural arbitration model.
module tb_bus_arbiter;

    localparam int N        = 4;
    localparam int W        = 32;
    localparam int M        = 8;
    localparam int MAX_LOCK = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   lock = '0;
    logic [N*W-1:0] data_in = '0;
    logic [N*M-1:0] ld_mask = '0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   bus;
    logic [M-1:0]   ld_en;
    logic           busy;
    logic           timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .N        (N),
        .W        (W),
        .M        (M),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk     (clk),
        .reset   (rst_n),
        .req     (req),
        .lock    (lock),
        .data_in (data_in),
        .ld_mask (ld_mask),
        .gnt     (gnt),
        .bus     (bus),
        .ld_en   (ld_en),
        .busy    (busy),
        .timeout (timeout)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [3:0]  gnt;
        logic        busy;
        logic        to;
        logic [31:0] bus;
        logic [7:0]  ld;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: owner index (-1 = bus free), rotating pointer, hold count.
    int m_own, m_ptr, m_cnt;
    bit m_to;

    task automatic model_reset();
        m_own = -1;
        m_ptr = 0;
        m_cnt = 0;
        m_to  = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
        bit again;
        bit to_n;
        to_n  = 0;
        again = 0;
        if (m_own < 0) begin
            again = (r != 0);
        end else if (r[m_own] && l[m_own] && m_cnt < MAX_LOCK) begin
            m_cnt++;
        end else begin
            to_n  = r[m_own] && l[m_own];
            again = 1;
        end
        if (again) begin
            if (r == 0) begin
                m_own = -1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (r[c]) begin
                        m_own = c;
                        break;
                    end
                end
                m_ptr = (m_own + 1) % N;
                m_cnt = 1;
            end
        end
        m_to = to_n;
    endtask

    task automatic model_check();
        logic [N-1:0] eg;
        logic [W-1:0] eb;
        logic [M-1:0] el;
        eg = '0;
        eb = '0;
        el = '0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            if (req[m_own]) begin
                eb = data_in[m_own*W +: W];
                el = ld_mask[m_own*M +: M];
            end
        end
        chk("rnd_gnt", gnt, eg);
        chk("rnd_busy", busy, (m_own >= 0));
        chk("rnd_timeout", timeout, m_to);
        chk("rnd_bus", bus, eb);
        chk("rnd_ld_en", ld_en, el);
        chk("rnd_onehot", $onehot0(gnt), 1);
        chk("rnd_ld_idle", (gnt == 0) && (ld_en != 0), 0);
    endtask

    initial begin
        tbl[0]  = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0,        8'h00};
        tbl[1]  = '{4'hF, 4'h0, 4'h1, 1'b1, 1'b0, 32'h11111111, 8'h01};
        tbl[2]  = '{4'hF, 4'h0, 4'h2, 1'b1, 1'b0, 32'hDEADBEEF, 8'h05};
        tbl[3]  = '{4'hF, 4'h0, 4'h4, 1'b1, 1'b0, 32'h33333333, 8'h30};
        tbl[4]  = '{4'hF, 4'h0, 4'h8, 1'b1, 1'b0, 32'h44444444, 8'hC0};
        tbl[5]  = '{4'h0, 4'h0, 4'h1, 1'b1, 1'b0, 32'h0,        8'h00};
        tbl[6]  = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0,        8'h00};
        tbl[7]  = '{4'h6, 4'h4, 4'h0, 1'b0, 1'b0, 32'h0,        8'h00};
        tbl[8]  = '{4'h6, 4'h4, 4'h2, 1'b1, 1'b0, 32'hDEADBEEF, 8'h05};
        for (int i = 9; i <= 16; i++)
            tbl[i] = '{4'h6, 4'h4, 4'h4, 1'b1, 1'b0, 32'h33333333, 8'h30};
        tbl[17] = '{4'h6, 4'h4, 4'h2, 1'b1, 1'b1, 32'hDEADBEEF, 8'h05};
        tbl[18] = '{4'h0, 4'h0, 4'h4, 1'b1, 1'b0, 32'h0,        8'h00};
        tbl[19] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0,        8'h00};

        data_in = {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111};
        ld_mask = {8'hC0, 8'h30, 8'h05, 8'h01};

        // Reset held with every requester asking.
        req = 4'hF;
        @(negedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_bus", bus, 0);
        chk("rst_ld_en", ld_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            req  = tbl[i].req;
            lock = tbl[i].lock;
            #1;
            chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_timeout", i), timeout, tbl[i].to);
            chk($sformatf("tbl%0d_bus", i), bus, tbl[i].bus);
            chk($sformatf("tbl%0d_ld_en", i), ld_en, tbl[i].ld);
        end

        // Asynchronous reset in the third locked transfer cycle.
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'h0;
        lock  = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'h1;
        lock  = 4'h1;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_gnt_pre", gnt, 4'h1);
        chk("mid_bus_pre", bus, 32'h11111111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_gnt", gnt, 0);
        chk("mid_bus", bus, 0);
        chk("mid_ld_en", ld_en, 0);
        chk("mid_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'hF;
        lock  = 4'h0;
        @(posedge clk);
        #1;
        chk("mid_restart_gnt", gnt, 4'h1);
        @(posedge clk);
        #1;
        chk("mid_restart_gnt2", gnt, 4'h2);

        // Random traffic against the model.
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'h0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge clk);
            req     = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            lock    = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            data_in = {$urandom, $urandom, $urandom, $urandom};
            ld_mask = $urandom;
            #1;
            model_check();
            @(posedge clk);
            model_step(req, lock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
